// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state enum, the RV32I funct3 width codes, and the
// byte-lane functions used for store merging and load extension.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      MERGE = 3'd2,
      WR    = 3'd3,
      DONE  = 3'd4
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Overlay the low store bytes onto the word read back from memory.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [2:0]  funct3);
      case (funct3)
         F3_B:    return {word[31:8],  data[7:0]};
         F3_H:    return {word[31:16], data[15:0]};
         default: return data;
      endcase
   endfunction

   // Sign/zero-extend the low lanes of a read word into a register value.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  funct3);
      case (funct3)
         F3_B:    return {{24{word[7]}},  word[7:0]};
         F3_BU:   return {24'd0,          word[7:0]};
         F3_H:    return {{16{word[15]}}, word[15:0]};
         F3_HU:   return {16'd0,          word[15:0]};
         default: return word;
      endcase
   endfunction

   // Width codes a load or a store may legally carry.
   function automatic logic f3_legal(input logic       is_store,
                                     input logic [2:0] funct3);
      if (is_store) return funct3 inside {F3_B, F3_H, F3_W};
      return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: turns one RV32I load/store into word transactions on a
// fixed-latency, byte-addressed data memory. Sub-word stores are done as
// read-modify-write. Every memory request is held stable for MEM_LAT cycles.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   req_i, is_store_i, funct3_i, addr_i, store_data_i : request, sampled in IDLE
//   busy_o, done_o, fault_o, load_data_o             : status / load result
//   mem_en_o, mem_wr_en_o, mem_addr_o, mem_data_o    : memory request
//   mem_data_i                                       : memory read data
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_LAT     = 5,
   parameter int unsigned ADDR_W      = 12,
   parameter bit          CHECK_ALIGN = 1'b0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_i,
   input  logic              is_store_i,
   input  logic [2:0]        funct3_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       store_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              fault_o,
   output logic [31:0]       load_data_o,
   output logic              mem_en_o,
   output logic              mem_wr_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   input  logic [31:0]       mem_data_i
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   lsu_state_e        r_state;
   lsu_state_e        w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_store;
   logic [2:0]        r_funct3;
   logic [31:0]       r_sdata;
   logic              r_fault;

   logic              r_busy;
   logic              r_done;
   logic              r_fault_o;
   logic [31:0]       r_load_data;
   logic              r_mem_en;
   logic              r_mem_wr;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_data;

   logic              w_accept;
   logic              w_misalign;
   logic              w_fault;
   logic              w_last;
   logic              w_is_sw;

   assign w_accept   = (r_state == IDLE) && req_i;
   assign w_is_sw    = is_store_i && (funct3_i == F3_W);
   assign w_misalign = CHECK_ALIGN &&
                       ((((funct3_i == F3_H) || (funct3_i == F3_HU)) && addr_i[0]) ||
                        ((funct3_i == F3_W) && (addr_i[1:0] != 2'b00)));
   assign w_fault    = ((addr_i >> ADDR_W) != 32'd0) ||
                       !f3_legal(is_store_i, funct3_i) || w_misalign;
   assign w_last     = (r_cnt == CNT_W'(MEM_LAT - 1));

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (req_i) begin
               if (w_fault)      w_state_next = DONE;
               else if (w_is_sw) w_state_next = WR;
               else              w_state_next = RD;
            end
         end
         RD:      if (w_last) w_state_next = MERGE;
         MERGE:   w_state_next = r_is_store ? WR : DONE;
         WR:      if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Hold counter: spans one memory window, 0..MEM_LAT-1
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         r_cnt <= '0;
      else if (((r_state == RD) || (r_state == WR)) && !w_last)
         r_cnt <= r_cnt + CNT_W'(1);
      else
         r_cnt <= '0;
   end

   // Request capture
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_is_store <= 1'b0;
         r_funct3   <= 3'd0;
         r_sdata    <= 32'd0;
         r_fault    <= 1'b0;
      end else if (w_accept) begin
         r_is_store <= is_store_i;
         r_funct3   <= funct3_i;
         r_sdata    <= store_data_i;
         r_fault    <= w_fault;
      end
   end

   // Registered outputs. Memory strobes follow the next state so they line up
   // exactly with the RD/WR windows; done/fault trail the DONE state by a cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fault_o   <= 1'b0;
         r_load_data <= 32'd0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= 32'd0;
      end else begin
         r_busy    <= (w_state_next != IDLE);
         r_done    <= (r_state == DONE);
         r_fault_o <= (r_state == DONE) && r_fault;
         r_mem_en  <= (w_state_next == RD) || (w_state_next == WR);
         r_mem_wr  <= (w_state_next == WR);
         if (w_accept && !w_fault) begin
            r_mem_addr <= addr_i[ADDR_W-1:0];
            if (w_is_sw) r_mem_data <= store_data_i;
         end
         if (r_state == MERGE) begin
            if (r_is_store) r_mem_data  <= store_merge(mem_data_i, r_sdata, r_funct3);
            else            r_load_data <= load_extend(mem_data_i, r_funct3);
         end
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign fault_o     = r_fault_o;
   assign load_data_o = r_load_data;
   assign mem_en_o    = r_mem_en;
   assign mem_wr_en_o = r_mem_wr;
   assign mem_addr_o  = r_mem_addr;
   assign mem_data_o  = r_mem_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory responder with fixed latency,
// a reference byte array updated per transaction from the ISA rules, and a
// second instance with alignment checking enabled sharing the same inputs.
module tb_load_store_unit;

   localparam int MEM_LAT = 5;
   localparam int ADDR_W  = 12;
   localparam int MSZ     = 4096;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic              is_store;
   logic [2:0]        funct3;
   logic [31:0]       addr;
   logic [31:0]       sdata;
   logic              busy, done, fault;
   logic [31:0]       load_data;
   logic              mem_en, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              a_busy, a_done, a_fault;
   logic [31:0]       a_load_data;
   logic              a_mem_en, a_mem_wr;
   logic [ADDR_W-1:0] a_mem_addr;
   logic [31:0]       a_mem_wdata;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .CHECK_ALIGN(1'b0)) dut (
      .clk_i(clk), .reset_i(reset), .req_i(req), .is_store_i(is_store),
      .funct3_i(funct3), .addr_i(addr), .store_data_i(sdata),
      .busy_o(busy), .done_o(done), .fault_o(fault), .load_data_o(load_data),
      .mem_en_o(mem_en), .mem_wr_en_o(mem_wr), .mem_addr_o(mem_addr),
      .mem_data_o(mem_wdata), .mem_data_i(mem_rdata));

   load_store_unit #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .CHECK_ALIGN(1'b1)) dut_a (
      .clk_i(clk), .reset_i(reset), .req_i(req), .is_store_i(is_store),
      .funct3_i(funct3), .addr_i(addr), .store_data_i(sdata),
      .busy_o(a_busy), .done_o(a_done), .fault_o(a_fault), .load_data_o(a_load_data),
      .mem_en_o(a_mem_en), .mem_wr_en_o(a_mem_wr), .mem_addr_o(a_mem_addr),
      .mem_data_o(a_mem_wdata), .mem_data_i(mem_rdata));

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [7:0]  mem     [MSZ];
   logic [7:0]  ref_mem [MSZ];
   bit          filled = 1'b0;
   bit          poke_en = 1'b0;
   int          poke_addr = 0;
   logic [31:0] poke_word = 32'd0;
   int          win = 0;
   logic [44:0] prev_req = '0;
   logic [44:0] cur_req;

   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < MSZ; i++) mem[i] = ref_mem[i];
         filled = 1'b1;
      end
      if (poke_en)
         for (int k = 0; k < 4; k++) mem[(poke_addr + k) % MSZ] = poke_word[8*k +: 8];
      if (reset) begin
         win = 0;
      end else if (mem_en) begin
         cur_req = {mem_wr, mem_addr, mem_wdata};
         if (win == 0) mem_rdata = $urandom;
         else chk("mem_req_stable", 32'(cur_req !== prev_req), 32'd0);
         prev_req = cur_req;
         win++;
         if (win == MEM_LAT) begin
            for (int k = 0; k < 4; k++) begin
               if (mem_wr) mem[(int'(mem_addr) + k) % MSZ] = mem_wdata[8*k +: 8];
               else        mem_rdata[8*k +: 8] = mem[(int'(mem_addr) + k) % MSZ];
            end
         end
         if (win > MEM_LAT) chk("mem_window_len", 32'(win), 32'(MEM_LAT));
      end else begin
         if (win != 0) chk("mem_window_len", 32'(win), 32'(MEM_LAT));
         win = 0;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_ld = 32'd0;

   function automatic logic [31:0] ref_word(input int a);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[(a + k) % MSZ];
      return w;
   endfunction

   function automatic logic [31:0] mem_word(input int a);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[(a + k) % MSZ];
      return w;
   endfunction

   task automatic poke(input int a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) ref_mem[(a + k) % MSZ] = w[8*k +: 8];
      poke_addr = a;
      poke_word = w;
      poke_en   = 1'b1;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   // One request; checks busy/done/fault timing of both instances every cycle.
   task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
      logic [31:0] w, v;
      int  lat, lat_a, n;
      bit  flt, flt_a, mis;
      flt   = (a >= 32'(MSZ)) ||
              (st ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                    f3 == 3'd4 || f3 == 3'd5));
      mis   = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
      flt_a = flt || mis;
      lat   = flt ? 2 : (!st ? MEM_LAT + 3 : (f3 == 3'd2 ? MEM_LAT + 2 : 2*MEM_LAT + 3));
      lat_a = flt_a ? 2 : lat;
      if (!flt) begin
         w = ref_word(int'(a));
         if (!st) begin
            case (f3)
               3'd0: begin v = w & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
               3'd1: begin v = w & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
               3'd4: v = w & 32'hFF;
               3'd5: v = w & 32'hFFFF;
               default: v = w;
            endcase
            exp_ld = v;
         end else begin
            n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
            for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % MSZ] = d[8*k +: 8];
         end
      end
      @(negedge clk);
      is_store = st; funct3 = f3; addr = a; sdata = d; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         if (k < lat) begin
            chk("busy_during", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
         end else begin
            chk("done_at_lat", 32'(done), 32'd1);
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("fault", 32'(fault), 32'(flt));
         end
         if (flt) chk("fault_no_mem_en", 32'(mem_en), 32'd0);
         if (k < lat_a)       chk("a_done_early", 32'(a_done), 32'd0);
         else if (k == lat_a) begin
            chk("a_done_at_lat", 32'(a_done), 32'd1);
            chk("a_fault", 32'(a_fault), 32'(flt_a));
         end
         // While both are busy, throw ignored requests at them.
         if (k < lat && lat_a == lat) begin
            req = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
            addr = $urandom; sdata = $urandom;
         end else begin
            req = 1'b0;
         end
         if (k < lat) @(negedge clk);
      end
      req = 1'b0;
      chk("load_data", load_data, exp_ld);
      if (st && !flt) chk("store_word", mem_word(int'(a)), ref_word(int'(a)));
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] sw_bytes [4];

   initial begin
      for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'($urandom);
      reset = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; sdata = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_data", mem_wdata, 32'd0);

      // SW then LW
      do_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
      sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int k = 0; k < 4; k++) chk("sw_byte_lit", 32'(mem[32'h100 + k]), 32'(sw_bytes[k]));
      do_txn(1'b0, 3'd2, 32'h100, 32'd0);
      chk("lw_lit", load_data, 32'hDEADBEEF);

      // Sub-word loads
      poke(32'h200, 32'h11223380);
      do_txn(1'b0, 3'd0, 32'h200, 32'd0); chk("lb_lit",  load_data, 32'hFFFFFF80);
      do_txn(1'b0, 3'd4, 32'h200, 32'd0); chk("lbu_lit", load_data, 32'h00000080);
      do_txn(1'b0, 3'd1, 32'h200, 32'd0); chk("lh_lit",  load_data, 32'h00003380);
      do_txn(1'b0, 3'd5, 32'h200, 32'd0); chk("lhu_lit", load_data, 32'h00003380);

      // Read-modify-write stores
      poke(32'h300, 32'hAABBCCDD);
      do_txn(1'b1, 3'd0, 32'h300, 32'h00000055);
      chk("sb_lit", mem_word(32'h300), 32'hAABBCC55);
      do_txn(1'b1, 3'd1, 32'h300, 32'h00001234);
      chk("sh_lit", mem_word(32'h300), 32'hAABB1234);

      // Faults and unaligned access
      do_txn(1'b0, 3'd2, 32'h00001000, 32'd0);
      chk("oor_ld_unchanged", load_data, 32'hAABB1234 & 32'h0 | 32'h00003380);
      do_txn(1'b0, 3'd2, 32'h102, 32'd0);
      do_txn(1'b1, 3'd4, 32'h180, 32'h12345678);

      // Reset in the WR window of an SB
      @(negedge clk);
      is_store = 1'b1; funct3 = 3'd0; addr = 32'h300; sdata = 32'h77; req = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) req = 1'b0;
      end
      chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
      chk("pre_rst_mem_wr", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_mem_en", 32'(mem_en), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_ld = 32'd0;
      for (int k = 0; k < 15; k++) begin
         chk("no_done_after_rst", 32'(done | a_done), 32'd0);
         @(negedge clk);
      end
      chk("rst_aborted_write", mem_word(32'h300), 32'hAABB1234);
      do_txn(1'b0, 3'd2, 32'h300, 32'd0);
      chk("lw_after_rst_lit", load_data, 32'hAABB1234);

      // req held for 20 cycles: one acceptance per IDLE cycle
      @(negedge clk);
      is_store = 1'b0; funct3 = 3'd2; addr = 32'h100; sdata = 32'd0; req = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         if (k == 20) req = 1'b0;
         if (k > 0) begin
            chk("held_done", 32'(done), 32'(k == 8 || k == 16 || k == 24));
            chk("held_busy", 32'(busy), 32'((k % 8 != 0) && k < 24));
         end
         @(negedge clk);
      end
      exp_ld = ref_word(32'h100);
      chk("held_load_data", load_data, 32'hDEADBEEF);

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         bit          st;
         logic [2:0]  f3;
         logic [31:0] a;
         int          sel;
         st  = 1'($urandom);
         f3  = 3'($urandom);
         if ($urandom_range(3) != 0) begin
            sel = st ? $urandom_range(2) : $urandom_range(4);
            f3  = (sel == 3) ? 3'd4 : (sel == 4) ? 3'd5 : 3'(sel);
         end
         case ($urandom_range(7))
            0:       a = $urandom;
            1:       a = 32'(MSZ - 1 - $urandom_range(2));
            default: a = 32'($urandom_range(MSZ - 1));
         endcase
         do_txn(st, f3, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory-access block that sits between the execute stage and `dataMemory`.
- Converts one RV32I load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into word transactions on the data-memory interface.
- Sub-word stores are done as read-modify-write, because the memory only writes 4 bytes at a time.
- The memory has a fixed, phase-blind sampling latency, so every transaction is held stable for MEM_LAT cycles.

Parameters:
- MEM_LAT, 5: cycles each memory request (en/wr_en/addr/data) is held stable. Must be ≥ 1.
- ADDR_W, 12: data-memory byte-address width.
- CHECK_ALIGN, 0: 1 = misaligned half/word accesses fault instead of being issued.

Ports:
- clk_i, input, 1: clock, rising edge.
- reset_i, input, 1: asynchronous, active-high reset.
- req_i, input, 1: request strobe; sampled only in IDLE.
- is_store_i, input, 1: 1 = store, 0 = load.
- funct3_i, input, 3: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr_i, input, 32: effective byte address.
- store_data_i, input, 32: store source (rs2).
- busy_o, output, 1: high from the accepted request until done_o.
- done_o, output, 1: one-cycle completion pulse.
- fault_o, output, 1: valid with done_o; misaligned, out-of-range, or illegal funct3.
- load_data_o, output, 32: extended load result; held until the next accepted load.
- mem_en_o, output, 1: memory enable.
- mem_wr_en_o, output, 1: memory write enable.
- mem_addr_o, output, ADDR_W: memory byte address.
- mem_data_o, output, 32: memory write data, little-endian (byte0 at addr).
- mem_data_i, input, 32: memory read data.

Behaviour:
- Clock/reset: one clock, clk_i. reset_i is asynchronous and active-high.
  - Reset values: busy_o, done_o, fault_o, mem_en_o, mem_wr_en_o = 0; load_data_o, mem_addr_o, mem_data_o = 0; state = IDLE; hold counter = 0.
  - Reset mid-transaction aborts it immediately. mem_en_o drops asynchronously. No partial write is retried.
- Capture: in IDLE with req_i=1, latch is_store, funct3, addr, store_data and assert busy_o next cycle. req_i while busy is ignored (no queueing).
- Fault checks, evaluated on capture:
  - addr_i[31:ADDR_W] ≠ 0 → fault.
  - Illegal funct3 → fault: loads accept {000,001,010,100,101}; stores accept {000,001,010}.
  - CHECK_ALIGN=1 and (H with addr[0]≠0, or W with addr[1:0]≠0) → fault.
  - A faulting request goes to DONE without touching memory: mem_en_o never rises, load_data_o unchanged.
- States: IDLE, RD, MERGE, WR, DONE.
  - IDLE → RD: load, or SB/SH.
  - IDLE → WR: SW.
  - IDLE → DONE: fault.
  - RD: mem_en_o=1, mem_wr_en_o=0, mem_addr_o=addr[ADDR_W-1:0]; held MEM_LAT cycles (counter 0..MEM_LAT-1). Next state: MERGE.
  - MERGE: one cycle; mem_en_o=0; sample mem_data_i.
    - Load: extend and write load_data_o, then go to DONE.
      - B: sign-extend byte0. BU: zero-extend byte0.
      - H: sign-extend bytes[1:0]. HU: zero-extend bytes[1:0].
      - W: full word.
    - SB: replace byte0 with store_data[7:0], keep bytes 1–3, go to WR.
    - SH: replace bytes[1:0] with store_data[15:0], keep bytes 2–3, go to WR.
  - WR: mem_en_o=1, mem_wr_en_o=1, mem_data_o = merged word (or store_data for SW); held MEM_LAT cycles. Next state: DONE.
  - DONE: done_o=1 for one cycle, busy_o drops in the same cycle, then → IDLE. A new req_i is accepted from the following IDLE cycle.
- Latency from req_i cycle to done_o:
  - Load: MEM_LAT+3.
  - SW: MEM_LAT+2.
  - SB/SH: 2·MEM_LAT+3.
  - Fault: 2.
- Addressing: the memory is byte-addressed, so unaligned accesses (CHECK_ALIGN=0) are legal and need no split. The memory's addr+1..+3 wrap modulo 2^ADDR_W; this block does not guard the wrap.
- Outputs are registered. mem_* are stable for the entire hold window and never change mid-window.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_e.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function store_merge(word, data, funct3).
  - Function load_extend(word, funct3).
- No sub-module. The hold counter is inline, width $clog2(MEM_LAT+1).

Test Plan (bench uses a behavioural byte-array memory model honouring MEM_LAT=5):
- SW 0xDEADBEEF @0x100, then LW @0x100 → memory bytes EF,BE,AD,DE; load_data_o=0xDEADBEEF; done_o 7 and 8 cycles after req_i respectively.
- Memory @0x200 = 0x11223380; LB @0x200 → 0xFFFFFF80; LBU → 0x00000080; LH → 0x00003380; LHU → 0x00003380.
- Memory @0x300 = 0xAABBCCDD; SB 0x55 @0x300 → word 0xAABBCC55; then SH 0x1234 @0x300 → 0xAABB1234; done_o 13 cycles after each req_i.
- LW @0x0000_1000 (out of range) → fault_o=1 with done_o 2 cycles after req_i, mem_en_o never asserted, load_data_o unchanged. With CHECK_ALIGN=1, LW @0x102 → fault. With CHECK_ALIGN=0, LW @0x102 → bytes 0x102..0x105.
- reset_i pulsed during the WR hold window of SB → mem_en_o=0 asynchronously, busy_o=0, no done_o; next LW completes normally.
- req_i held high for 20 cycles across an LW → exactly one transaction per IDLE acceptance; the second request starts only after done_o.
